// File: rtl/rca_config_sequencer_pkg.sv
// rca_config_sequencer_pkg: RCA instruction encodings, sequencer state and default sizing.
package rca_config_sequencer_pkg;

    localparam int DEFAULT_NUM_RCAS = 2;
    localparam int DEFAULT_TIMEOUT  = 1024;

    typedef enum logic [2:0] {
        RCA_USE          = 3'd0,
        IO_UNIT_CONFIG   = 3'd1,
        IO_MUX_CONFIG    = 3'd2,
        GRID_MUX_CONFIG  = 3'd3,
        GRID_UNIT_CONFIG = 3'd4,
        IO_USE_CONFIG    = 3'd5,
        RCA_RSVD6        = 3'd6,
        RCA_RSVD7        = 3'd7
    } rca_fn3_t;

    typedef logic [6:0] rca_fn7_t;

    typedef enum logic [2:0] {
        IDLE,
        CFG_WR,
        USE_START,
        USE_RUN,
        WB
    } rca_seq_state_t;

    function automatic logic is_cfg_op(input logic [2:0] f);
        return f >= 3'd1 && f <= 3'd5;
    endfunction

endpackage

// File: rtl/rca_config_sequencer_watchdog.sv
// rca_watchdog: loadable down-counter that flags expiry once it reaches zero.
module rca_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count;

    // Loaded with TIMEOUT-1 so zero is reached on the TIMEOUT-th enabled cycle.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= W'(TIMEOUT - 1);
        else if (en && count != '0)
            count <= count - W'(1);
    end

    assign expired = count == '0;
endmodule

// File: rtl/rca_config_sequencer.sv
// rca_config_sequencer: issues RCA config writes and USE runs, one instruction in flight, with completion writeback.
module rca_config_sequencer
    import rca_config_sequencer_pkg::*;
#(
    parameter int NUM_RCAS   = DEFAULT_NUM_RCAS,
    parameter int CFG_ADDR_W = 8,
    parameter int ID_W       = 3,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic [2:0]                  issue_fn3,
    input  logic [$clog2(NUM_RCAS)-1:0] issue_rca_sel,
    input  logic [31:0]                 issue_rs1,
    input  logic [31:0]                 issue_rs2,
    input  logic [ID_W-1:0]             issue_id,
    output logic                        cfg_wr,
    output logic [2:0]                  cfg_target,
    output logic [$clog2(NUM_RCAS)-1:0] cfg_rca,
    output logic [CFG_ADDR_W-1:0]       cfg_addr,
    output logic [31:0]                 cfg_data,
    input  logic                        cfg_ack,
    output logic                        rca_start,
    output logic [$clog2(NUM_RCAS)-1:0] rca_idx,
    output logic [31:0]                 rca_op_a,
    output logic [31:0]                 rca_op_b,
    input  logic                        rca_done,
    input  logic [31:0]                 rca_result,
    output logic                        wb_valid,
    input  logic                        wb_ack,
    output logic [ID_W-1:0]             wb_id,
    output logic [31:0]                 wb_data,
    output logic                        wb_err,
    output logic [NUM_RCAS-1:0]         configured
);
    rca_seq_state_t state, state_next;
    rca_fn3_t fn3_r;
    logic [$clog2(NUM_RCAS)-1:0] sel_r;
    logic [31:0] rs1_r, rs2_r, wb_data_r;
    logic [ID_W-1:0] id_r;
    logic wb_err_r, expired, accept;
    logic [NUM_RCAS-1:0] configured_r;

    assign accept = state == IDLE && issue_valid;

    rca_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .load    (state == USE_START),
        .en      (state == USE_RUN),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (issue_valid) state_next = is_cfg_op(issue_fn3) ? CFG_WR :
                                                     (issue_fn3 == RCA_USE && configured_r[issue_rca_sel]) ? USE_START : WB;
            CFG_WR:    if (cfg_ack) state_next = WB;
            USE_START: state_next = USE_RUN;
            USE_RUN:   if (rca_done || expired) state_next = WB;
            WB:        if (wb_ack) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        issue_ready = state == IDLE;
        cfg_wr      = state == CFG_WR;
        rca_start   = state == USE_START;
        wb_valid    = state == WB;
    end

    // Rejected instructions get their error completion decided at accept time.
    always_ff @(posedge clk) begin
        if (rst) begin
            fn3_r        <= RCA_USE;
            sel_r        <= '0;
            rs1_r        <= '0;
            rs2_r        <= '0;
            id_r         <= '0;
            wb_data_r    <= '0;
            wb_err_r     <= 1'b0;
            configured_r <= '0;
        end else begin
            if (accept) begin
                fn3_r     <= rca_fn3_t'(issue_fn3);
                sel_r     <= issue_rca_sel;
                rs1_r     <= issue_rs1;
                rs2_r     <= issue_rs2;
                id_r      <= issue_id;
                wb_data_r <= '0;
                wb_err_r  <= !is_cfg_op(issue_fn3) && !(issue_fn3 == RCA_USE && configured_r[issue_rca_sel]);
            end
            if (state == CFG_WR && cfg_ack)
                configured_r[sel_r] <= fn3_r == IO_USE_CONFIG;
            if (state == USE_RUN && (rca_done || expired)) begin
                wb_data_r <= rca_done ? rca_result : '1;
                wb_err_r  <= !rca_done;
            end
        end
    end

    assign cfg_target = fn3_r;
    assign cfg_rca    = sel_r;
    assign cfg_addr   = rs1_r[CFG_ADDR_W-1:0];
    assign cfg_data   = rs2_r;
    assign rca_idx    = sel_r;
    assign rca_op_a   = rs1_r;
    assign rca_op_b   = rs2_r;
    assign wb_id      = id_r;
    assign wb_data    = wb_data_r;
    assign wb_err     = wb_err_r;
    assign configured = configured_r;
endmodule

// File: tb/tb_rca_config_sequencer.sv
// tb_rca_config_sequencer: vector table, reset sequences and randomized traffic checked against a reference model.
module tb_rca_config_sequencer;
    localparam int TO = 16;

    logic        clk, rst;
    logic        issue_valid, issue_ready;
    logic [2:0]  issue_fn3;
    logic        issue_rca_sel;
    logic [31:0] issue_rs1, issue_rs2;
    logic [2:0]  issue_id;
    logic        cfg_wr;
    logic [2:0]  cfg_target;
    logic        cfg_rca;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_ack;
    logic        rca_start;
    logic        rca_idx;
    logic [31:0] rca_op_a, rca_op_b;
    logic        rca_done;
    logic [31:0] rca_result;
    logic        wb_valid, wb_ack;
    logic [2:0]  wb_id;
    logic [31:0] wb_data;
    logic        wb_err;
    logic [1:0]  configured;

    rca_config_sequencer #(.NUM_RCAS(2), .CFG_ADDR_W(8), .ID_W(3), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_fn3(issue_fn3),
        .issue_rca_sel(issue_rca_sel), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_id(issue_id),
        .cfg_wr(cfg_wr), .cfg_target(cfg_target), .cfg_rca(cfg_rca), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_ack(cfg_ack),
        .rca_start(rca_start), .rca_idx(rca_idx), .rca_op_a(rca_op_a), .rca_op_b(rca_op_b),
        .rca_done(rca_done), .rca_result(rca_result),
        .wb_valid(wb_valid), .wb_ack(wb_ack), .wb_id(wb_id), .wb_data(wb_data), .wb_err(wb_err),
        .configured(configured)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fn3;
        logic        sel;
        logic [31:0] rs1, rs2;
        logic [2:0]  id;
        int          ack_d, done_d, wb_d;
        logic [31:0] res, exp_data;
        logic        exp_err, exp_start;
        logic [1:0]  exp_cfg;
        int          exp_lat;
    } vec_t;

    int n_chk = 0, n_fail = 0;
    logic [1:0] mcfg;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference: completion latency counted from the accept cycle, outcome from the instruction rules.
    function automatic vec_t model(input vec_t v);
        vec_t e = v;
        e.exp_start = 1'b0;
        e.exp_data  = '0;
        e.exp_err   = 1'b1;
        e.exp_lat   = 1;
        if (v.fn3 >= 3'd1 && v.fn3 <= 3'd5) begin
            e.exp_err = 1'b0;
            e.exp_lat = 2 + v.ack_d;
            mcfg[v.sel] = v.fn3 == 3'd5;
        end else if (v.fn3 == 3'd0 && mcfg[v.sel]) begin
            e.exp_start = 1'b1;
            if (v.done_d >= 1 && v.done_d <= TO) begin
                e.exp_err  = 1'b0;
                e.exp_data = v.res;
                e.exp_lat  = 2 + v.done_d;
            end else begin
                e.exp_data = '1;
                e.exp_lat  = 2 + TO;
            end
        end
        e.exp_cfg = mcfg;
        return e;
    endfunction

    task automatic run(input vec_t v);
        int c, wb_first, start_cyc, cfgn, startn, ready_hi;
        logic cfg_stable, wb_stable, acked, s_rca, s_idx, s_werr;
        logic [31:0] s_cdata, s_a, s_b, s_wdata;
        logic [7:0] s_addr;
        logic [2:0] s_tgt, s_wid;
        {s_rca, s_idx, s_werr, s_cdata, s_a, s_b, s_wdata, s_addr, s_tgt, s_wid} = '0;
        chk("ready_idle", issue_ready, 1);
        issue_valid = 1'b1; issue_fn3 = v.fn3; issue_rca_sel = v.sel;
        issue_rs1 = v.rs1; issue_rs2 = v.rs2; issue_id = v.id;
        step;
        issue_valid = 1'b0; issue_fn3 = 3'($urandom); issue_rca_sel = 1'($urandom);
        issue_rs1 = $urandom; issue_rs2 = $urandom; issue_id = 3'($urandom);
        c = 1; wb_first = -1; start_cyc = -1; cfgn = 0; startn = 0; ready_hi = 0;
        cfg_stable = 1'b1; wb_stable = 1'b1; acked = 1'b0;
        while (!acked && c < 200) begin
            if (issue_ready) ready_hi++;
            if (cfg_wr) begin
                if (cfgn == 0) {s_tgt, s_rca, s_addr, s_cdata} = {cfg_target, cfg_rca, cfg_addr, cfg_data};
                else if ({s_tgt, s_rca, s_addr, s_cdata} !== {cfg_target, cfg_rca, cfg_addr, cfg_data}) cfg_stable = 1'b0;
                cfgn++;
            end
            cfg_ack = cfg_wr ? (cfgn - 1 >= v.ack_d) : 1'($urandom);
            if (rca_start) begin
                startn++; start_cyc = c; s_a = rca_op_a; s_b = rca_op_b; s_idx = rca_idx;
            end
            if (start_cyc >= 0 && !rca_start && !wb_valid) begin
                rca_done = (c - start_cyc == v.done_d); rca_result = v.res;
            end else begin
                rca_done = 1'($urandom); rca_result = $urandom;
            end
            if (wb_valid) begin
                if (wb_first < 0) begin
                    wb_first = c; s_wdata = wb_data; s_werr = wb_err; s_wid = wb_id;
                end else if ({s_wdata, s_werr, s_wid} !== {wb_data, wb_err, wb_id}) wb_stable = 1'b0;
                wb_ack = (c - wb_first >= v.wb_d);
            end else wb_ack = 1'b0;
            acked = wb_valid && wb_ack;
            step;
            c++;
        end
        cfg_ack = 1'b0; rca_done = 1'b0; wb_ack = 1'b0;
        chk("completed", acked, 1);
        chk("wb_latency", wb_first, v.exp_lat);
        chk("wb_data", s_wdata, v.exp_data);
        chk("wb_err", s_werr, v.exp_err);
        chk("wb_id", s_wid, v.id);
        chk("wb_stable", wb_stable, 1);
        chk("cfg_wr_cycles", cfgn, (v.fn3 >= 3'd1 && v.fn3 <= 3'd5) ? v.ack_d + 1 : 0);
        if (cfgn > 0) begin
            chk("cfg_addr", s_addr, v.rs1[7:0]);
            chk("cfg_data", s_cdata, v.rs2);
            chk("cfg_target", s_tgt, v.fn3);
            chk("cfg_rca", s_rca, v.sel);
            chk("cfg_stable", cfg_stable, 1);
        end
        chk("start_pulses", startn, v.exp_start);
        if (startn > 0) begin
            chk("start_cycle", start_cyc, 1);
            chk("rca_op_a", s_a, v.rs1);
            chk("rca_op_b", s_b, v.rs2);
            chk("rca_idx", s_idx, v.sel);
        end
        chk("ready_in_flight", ready_hi, 0);
        chk("configured", configured, v.exp_cfg);
        chk("ready_after", issue_ready, 1);
        chk("wb_valid_after", wb_valid, 0);
    endtask

    initial begin
        tbl[0]  = '{3'd2, 1'b1, 32'h5,         32'hDEADBEEF,  3'd1, 0, 0,  0, 32'h0,        32'h0,        1'b0, 1'b0, 2'b00, 2};
        tbl[1]  = '{3'd5, 1'b0, 32'h12,        32'h1,         3'd2, 0, 0,  1, 32'h0,        32'h0,        1'b0, 1'b0, 2'b01, 2};
        tbl[2]  = '{3'd0, 1'b0, 32'd3,         32'd4,         3'd3, 0, 5,  0, 32'd7,        32'd7,        1'b0, 1'b1, 2'b01, 7};
        tbl[3]  = '{3'd0, 1'b1, 32'h9,         32'h9,         3'd4, 0, 2,  0, 32'h99,       32'h0,        1'b1, 1'b0, 2'b01, 1};
        tbl[4]  = '{3'd0, 1'b0, 32'h1,         32'h2,         3'd5, 0, -1, 1, 32'h55,       32'hFFFFFFFF, 1'b1, 1'b1, 2'b01, 18};
        tbl[5]  = '{3'd5, 1'b1, 32'hFFFF_FFA7, 32'h5555_AAAA, 3'd6, 3, 0,  2, 32'h0,        32'h0,        1'b0, 1'b0, 2'b11, 5};
        tbl[6]  = '{3'd7, 1'b0, 32'h3,         32'h4,         3'd7, 0, 0,  0, 32'h0,        32'h0,        1'b1, 1'b0, 2'b11, 1};
        tbl[7]  = '{3'd6, 1'b1, 32'h5,         32'h6,         3'd0, 0, 0,  1, 32'h0,        32'h0,        1'b1, 1'b0, 2'b11, 1};
        tbl[8]  = '{3'd1, 1'b0, 32'h77,        32'h88,        3'd1, 1, 0,  0, 32'h0,        32'h0,        1'b0, 1'b0, 2'b10, 3};
        tbl[9]  = '{3'd0, 1'b0, 32'h8,         32'h9,         3'd2, 0, 3,  0, 32'h11,       32'h0,        1'b1, 1'b0, 2'b10, 1};
        tbl[10] = '{3'd0, 1'b1, 32'hA,         32'hB,         3'd3, 0, 16, 0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 2'b10, 18};
        tbl[11] = '{3'd0, 1'b1, 32'hC,         32'hD,         3'd4, 0, 1,  0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b1, 2'b10, 3};

        rst = 1'b1; issue_valid = 1'b0; issue_fn3 = '0; issue_rca_sel = 1'b0;
        issue_rs1 = '0; issue_rs2 = '0; issue_id = '0;
        cfg_ack = 1'b0; rca_done = 1'b0; rca_result = '0; wb_ack = 1'b0;
        repeat (3) step;
        rst = 1'b0;
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_configured", configured, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_cfg_wr", cfg_wr, 0);
        chk("rst_rca_start", rca_start, 0);
        chk("rst_wb_err", wb_err, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_id", wb_id, 0);
        chk("rst_cfg_fields", {cfg_addr, cfg_data, cfg_rca, cfg_target}, 0);
        chk("rst_rca_ops", {rca_op_a, rca_op_b, rca_idx}, 0);

        for (int i = 0; i < 12; i++) run(tbl[i]);

        // Reset in the middle of a run on rca 1, then a late done.
        issue_valid = 1'b1; issue_fn3 = 3'd0; issue_rca_sel = 1'b1;
        issue_rs1 = 32'h11; issue_rs2 = 32'h22; issue_id = 3'd6;
        step;
        issue_valid = 1'b0;
        chk("rstrun_start", rca_start, 1);
        repeat (3) step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("rstrun_ready", issue_ready, 1);
        chk("rstrun_configured", configured, 0);
        chk("rstrun_wb_valid", wb_valid, 0);
        chk("rstrun_ops", {rca_op_a, rca_op_b}, 0);
        chk("rstrun_wb_id", wb_id, 0);
        rca_done = 1'b1; rca_result = 32'h5A5A;
        repeat (3) begin
            step;
            chk("late_done_wb", wb_valid, 0);
            chk("late_done_ready", issue_ready, 1);
        end
        rca_done = 1'b0;

        // Reset while an error completion is pending.
        issue_valid = 1'b1; issue_fn3 = 3'd7; issue_id = 3'd5;
        step;
        issue_valid = 1'b0;
        chk("rstwb_pending", {wb_valid, wb_err, wb_id}, {1'b1, 1'b1, 3'd5});
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("rstwb_cleared", {wb_valid, wb_err, wb_id, issue_ready}, {1'b0, 1'b0, 3'd0, 1'b1});

        mcfg = 2'b00;
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            int r;
            r = $urandom_range(0, 9);
            v.fn3 = r < 4 ? 3'd0 : r < 7 ? 3'd5 : 3'($urandom);
            v.sel = 1'($urandom);
            v.rs1 = $urandom; v.rs2 = $urandom; v.id = 3'($urandom);
            v.ack_d = $urandom_range(0, 3);
            v.done_d = $urandom_range(1, 20);
            v.wb_d = $urandom_range(0, 2);
            v.res = $urandom;
            run(model(v));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rca_config_sequencer.md
RCA_CONFIG_SEQUENCER -- requirements
Module: rca_config_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_RCAS, 2, number of reconfigurable accelerators.
- CFG_ADDR_W, 8, config table address width.
- ID_W, 3, instruction ID width.
- TIMEOUT, 1024, maximum USE run cycles.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: clock. One clock; all logic on its rising edge.
- rst, in, 1: reset. Synchronous and active-high.
- issue_valid, in, 1: RCA instruction offered.
- issue_ready, out, 1: sequencer can accept.
- issue_fn3, in, 3: rca_fn3_t operation.
- issue_rca_sel, in, $clog2(NUM_RCAS): target accelerator.
- issue_rs1, in, 32: config address (low CFG_ADDR_W bits) or operand A.
- issue_rs2, in, 32: config data or operand B.
- issue_id, in, ID_W: instruction ID.
- cfg_wr, out, 1: config write request.
- cfg_target, out, 3: config table (fn3 value).
- cfg_rca, out, $clog2(NUM_RCAS): accelerator being configured.
- cfg_addr, out, CFG_ADDR_W: config table address.
- cfg_data, out, 32: config word.
- cfg_ack, in, 1: config write accepted.
- rca_start, out, 1: one-cycle USE start pulse.
- rca_idx, out, $clog2(NUM_RCAS): accelerator to run.
- rca_op_a, out, 32: operand A.
- rca_op_b, out, 32: operand B.
- rca_done, in, 1: accelerator finished.
- rca_result, in, 32: accelerator result.
- wb_valid, out, 1: completion available.
- wb_ack, in, 1: completion consumed.
- wb_id, out, ID_W: completion ID.
- wb_data, out, 32: completion data.
- wb_err, out, 1: completion is an error.
- configured, out, NUM_RCAS: per-accelerator "configuration complete" flags.

Function
REQ-003 The FSM SHALL have five states: IDLE, CFG_WR, USE_START, USE_RUN, WB; exactly one instruction is in flight.
REQ-004 issue_ready SHALL be 1 only in IDLE; an instruction is accepted on a cycle where issue_valid and issue_ready are both 1, and fn3, rca_sel, rs1, rs2 and id are registered on that cycle.
REQ-005 Accepting fn3 in 001..101 (config ops) SHALL go to CFG_WR.
REQ-006 Accepting fn3 000 (USE) SHALL go to USE_START if configured[rca_sel]=1, else to WB with wb_err=1 and wb_data=0.
REQ-007 Accepting fn3 110 or 111 SHALL go to WB with wb_err=1 and wb_data=0.
REQ-008 In CFG_WR, cfg_wr SHALL be 1 and cfg_target/cfg_rca/cfg_addr/cfg_data SHALL be held stable until cfg_ack=1, then go to WB with wb_err=0 and wb_data=0; cfg_ack is honoured in the first CFG_WR cycle.
REQ-009 On an acked write, IO_USE_CONFIG (101) SHALL set configured[cfg_rca]; any other config fn3 SHALL clear it.
REQ-010 USE_START SHALL last one cycle with rca_start=1, rca_idx, rca_op_a=rs1 and rca_op_b=rs2, then go to USE_RUN.
REQ-011 In USE_RUN, rca_done=1 SHALL capture rca_result into wb_data (wb_err=0) and go to WB.
REQ-012 A watchdog counter SHALL reset on entry to USE_RUN; if TIMEOUT cycles elapse without rca_done, the FSM SHALL go to WB with wb_err=1 and wb_data=32'hFFFF_FFFF.
REQ-013 rca_done and cfg_ack outside USE_RUN and CFG_WR respectively SHALL be ignored.
REQ-014 In WB, wb_valid, wb_id, wb_data and wb_err SHALL be held until wb_ack=1, then return to IDLE; the next instruction is accepted no earlier than the following cycle.
REQ-015 Latency SHALL be: config write with immediate ack accepted in cycle N gives cfg_wr in N+1 and wb_valid in N+2; USE accepted in N gives rca_start in N+1, and rca_done in cycle M gives wb_valid in M+1.
REQ-016 All outputs SHALL be registered or decoded only from state registers, with no combinational path from inputs to outputs.

Reset
REQ-017 rst SHALL return the FSM to IDLE, abandoning any in-flight write, run or completion.
REQ-018 rst SHALL clear configured, cfg_wr, rca_start, wb_valid, wb_err and the watchdog counter.
REQ-019 rst SHALL zero wb_data, wb_id, cfg_* and rca_op_*.
REQ-020 issue_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-021 rca_fn3_t and rca_fn7_t SHALL remain in riscv_types; the FSM state enum SHALL be added to taiga_types.
REQ-022 NUM_RCAS and TIMEOUT defaults SHALL be defined in taiga_config.
REQ-023 One sub-module, rca_watchdog (loadable down-counter with expiry flag), is natural; everything else is inline.

Verification
REQ-024 Scenario: IO_MUX_CONFIG, rca 1, rs1=0x05, rs2=0xDEADBEEF, cfg_ack held high -> cfg_wr one cycle with addr 0x05 and data 0xDEADBEEF, then wb_valid with err=0 and data=0, and configured=2'b00.
REQ-025 Scenario: IO_USE_CONFIG on rca 0, then USE on rca 0 with rs1=3, rs2=4, and rca_done 5 cycles after start with result 7 -> configured[0]=1, one rca_start pulse, wb_data=7, err=0.
REQ-026 Scenario: USE on unconfigured rca 1 -> no rca_start, wb_err=1, wb_data=0.
REQ-027 Scenario: USE with rca_done never asserted, TIMEOUT=16 -> wb_err=1, wb_data=0xFFFFFFFF, 16 cycles after entering USE_RUN.
REQ-028 Scenario: cfg_ack delayed 3 cycles with wb_ack delayed 2 cycles -> cfg_* and wb_* stable throughout and issue_ready=0; separately, rst asserted during USE_RUN -> IDLE next cycle, configured cleared, and a late rca_done ignored.
